// File: rtl/dsp_fft_reorder_pkg.sv
// Shared constants and types for the FFT bit-reversal reorder buffer.
// A packed complex word is {re, im}, each DSP_DATA_W wide.
package dsp_fft_reorder_pkg;

    localparam int DSP_DATA_W = 16;
    localparam int DSP_LOG2N  = 3;
    localparam int DSP_IM_LSB = 0;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

endpackage

// File: rtl/simple_dpram.sv
// One write port, one synchronous read port; read data holds while re is low.
module simple_dpram #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/dsp_fft_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT bins in, natural order out.
// A bank is released once its last address is read, so writes can refill it.
module dsp_fft_reorder
    import dsp_fft_reorder_pkg::*;
#(
    parameter int DATA_W = DSP_DATA_W,
    parameter int LOG2N  = DSP_LOG2N
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2*DATA_W-1:0] din,
    input  logic                din_vld,
    output logic [2*DATA_W-1:0] dout,
    output logic                dout_vld,
    input  logic                dout_rdy,
    output logic                dout_last,
    output logic                overflow
);

    localparam int W = 2*DATA_W;
    localparam logic [LOG2N-1:0] LAST = '1;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++)
            r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    logic [LOG2N-1:0] wcnt;
    logic [LOG2N-1:0] rcnt;
    logic [LOG2N-1:0] waddr;
    logic             wbank;
    logic             rbank;
    logic [1:0]       full;
    rd_state_t        state;

    logic             accept;
    logic             drop;
    logic             issue;
    logic             adv_out;
    logic             adv_s1;
    logic [1:0]       we;
    logic [1:0]       re;
    logic [W-1:0]     rdata [2];

    logic             s1_vld;
    logic             s1_last;
    logic             s1_bank;

    assign accept  = din_vld && !full[wbank];
    assign drop    = din_vld && full[wbank];
    assign waddr   = bitrev(wcnt);
    assign adv_out = !dout_vld || dout_rdy;
    assign adv_s1  = !s1_vld || adv_out;
    assign issue   = adv_s1 && (state == RD_STREAM || full[rbank]);

    always_comb begin
        we = '0;
        re = '0;
        we[wbank] = accept;
        re[rbank] = issue;
    end

    simple_dpram #(.WIDTH(W), .DEPTH_LOG2(LOG2N)) simple_dpram_0 (
        .clk   (clk),
        .we    (we[0]),
        .waddr (waddr),
        .wdata (din),
        .re    (re[0]),
        .raddr (rcnt),
        .rdata (rdata[0])
    );

    simple_dpram #(.WIDTH(W), .DEPTH_LOG2(LOG2N)) simple_dpram_1 (
        .clk   (clk),
        .we    (we[1]),
        .waddr (waddr),
        .wdata (din),
        .re    (re[1]),
        .raddr (rcnt),
        .rdata (rdata[1])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt     <= '0;
            wbank    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= drop;
            if (accept) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt == LAST)
                    wbank <= ~wbank;
            end
        end
    end

    // set and clear never target the same bank in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else begin
            if (issue && rcnt == LAST)
                full[rbank] <= 1'b0;
            if (accept && wcnt == LAST)
                full[wbank] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RD_IDLE;
            rcnt      <= '0;
            rbank     <= 1'b0;
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            s1_bank   <= 1'b0;
            dout      <= '0;
            dout_vld  <= 1'b0;
            dout_last <= 1'b0;
        end else begin
            if (issue) begin
                rcnt <= rcnt + 1'b1;
                if (rcnt == LAST) begin
                    state <= RD_IDLE;
                    rbank <= ~rbank;
                end else begin
                    state <= RD_STREAM;
                end
            end
            if (adv_s1) begin
                s1_vld  <= issue;
                s1_last <= issue && rcnt == LAST;
                s1_bank <= rbank;
            end
            if (adv_out) begin
                dout_vld  <= s1_vld;
                dout_last <= s1_vld && s1_last;
                if (s1_vld)
                    dout <= rdata[s1_bank];
            end
        end
    end

endmodule
